hci_core_r_responder: RTL and testbench
=======================================

HCI_CORE_R_RESPONDER -- requirements
Module: hci_core_r_responder

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter UW, default 1, user width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, response buffer entries, legal range 1..8.
REQ-005 SHALL have parameter R_VALID_ON_WRITE, default 1; 1 = respond to reads and writes, 0 = respond to reads only.
REQ-006 SHALL have port clk_i  input  1  single clock, all logic on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port clear_i  input  1  synchronous flush.
REQ-009 SHALL have port tcdm_slave  hci_core_intf.slave  DW/AW/UW  request in, response out: req, add, wen, data, be, user, lrdy in; gnt, r_valid, r_data, r_opc, r_user out.
REQ-010 SHALL have port mem_req_o  output  1  SRAM access strobe.
REQ-011 SHALL have port mem_add_o  output  AW  SRAM address.
REQ-012 SHALL have port mem_wen_o  output  1  1 = read, 0 = write.
REQ-013 SHALL have port mem_be_o  output  DW/8  byte enables.
REQ-014 SHALL have port mem_data_o  output  DW  write data.
REQ-015 SHALL have port mem_data_i  input  DW  read data, valid exactly one cycle after mem_req_o.

Function
REQ-016 SHALL track occupancy: cnt = FIFO entries, s1_valid = in-flight access in pipeline stage.
REQ-017 SHALL drive gnt = req & ~clear_i & (cnt + s1_valid < FIFO_DEPTH); gnt SHALL NOT depend combinationally on lrdy.
REQ-018 SHALL drive mem_req_o = req & gnt; mem_add_o/wen_o/be_o/data_o SHALL pass through tcdm_slave fields.
REQ-019 SHALL, on req & gnt, load stage register with wen, user, respond flag = (wen | R_VALID_ON_WRITE).
REQ-020 SHALL, at cycle T+1 after a grant at T with respond flag set, present the response: r_data = mem_data_i for reads, 0 for writes; r_user = stored user; r_opc = 0.
REQ-021 SHALL use fall-through: if FIFO empty at T+1, r_valid asserts at T+1 directly from stage (minimum latency 1 cycle); if r_valid & lrdy, nothing is pushed.
REQ-022 SHALL push the stage response into the FIFO when FIFO non-empty or lrdy = 0.
REQ-023 SHALL, when FIFO non-empty, drive r_valid = 1 with head entry; pop on r_valid & lrdy; strict in-order delivery.
REQ-024 SHALL hold r_valid, r_data, r_user, r_opc stable while r_valid & ~lrdy.
REQ-025 SHALL discard stage entries with respond flag 0 (no r_valid, no FIFO push).
REQ-026 SHALL allow simultaneous push and pop in one cycle; cnt unchanged.
REQ-027 SHALL sustain one grant per cycle with lrdy = 1 continuously for FIFO_DEPTH >= 2.
REQ-028 SHALL on clear_i = 1 clear cnt, FIFO pointers and s1_valid next edge; a read in flight at clear is dropped, no r_valid for it.
REQ-029 SHALL never overflow: cnt <= FIFO_DEPTH at all times; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, while rst_ni = 0, force cnt = 0, pointers = 0, s1_valid = 0.
REQ-031 SHALL output after reset: gnt = req, r_valid = 0, r_data = 0, r_user = 0, r_opc = 0, mem_req_o = req.
REQ-032 SHALL drop all pending responses on reset assertion mid-operation; no r_valid in first cycle after release.

Verification
REQ-033 SHALL cover: read add=0x10, mem returns 0xCAFE0001, lrdy=1 -> gnt at T, r_valid=1 r_data=0xCAFE0001 at T+1 only.
REQ-034 SHALL cover: R_VALID_ON_WRITE=0, write then read back-to-back -> exactly one r_valid, at read grant +1.
REQ-035 SHALL cover: FIFO_DEPTH=2, lrdy=0, 4 reads requested -> 2 grants, then gnt=0; lrdy=1 -> responses in issue order, gnt resumes.
REQ-036 SHALL cover: lrdy toggling 1/0 with continuous reads -> r_data stable during every stall, no loss or duplication.
REQ-037 SHALL cover: clear_i pulse with 1 FIFO entry + 1 in flight -> r_valid=0 next cycle, cnt=0, gnt=req.
REQ-038 SHALL cover: rst_ni asserted with full FIFO -> r_valid=0 immediately, gnt=req after release.

Source files
------------

// File: rtl/hci_core_r_responder_if.sv
// +--------------------------------------------------------------+
// | hci_core_intf : TCDM-style request / response bundle         |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 1
);
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [UW-1:0]   user;
  logic            lrdy;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic            r_opc;
  logic [UW-1:0]   r_user;

  modport master (
    output req, add, wen, data, be, user, lrdy,
    input  gnt, r_valid, r_data, r_opc, r_user
  );
  modport slave (
    input  req, add, wen, data, be, user, lrdy,
    output gnt, r_valid, r_data, r_opc, r_user
  );
endinterface

`default_nettype wire

// File: rtl/hci_core_r_responder.sv
// +--------------------------------------------------------------+
// | hci_core_r_responder : SRAM front-end with fall-through      |
// | response FIFO and occupancy-based grant.  Rev 1.0            |
// +--------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hci_core_r_responder #(
  parameter int unsigned DW               = 32,
  parameter int unsigned AW               = 32,
  parameter int unsigned UW               = 1,
  parameter int unsigned FIFO_DEPTH       = 2,
  parameter bit          R_VALID_ON_WRITE = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  hci_core_intf.slave     tcdm_slave,
  output logic            mem_req_o,
  output logic [AW-1:0]   mem_add_o,
  output logic            mem_wen_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_data_o,
  input  logic [DW-1:0]   mem_data_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_wen_q, s1_wen_d;
  logic          s1_resp_q, s1_resp_d;
  logic [UW-1:0] s1_user_q, s1_user_d;
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_d [FIFO_DEPTH];
  logic [UW-1:0] fifo_user_q [FIFO_DEPTH];
  logic [UW-1:0] fifo_user_d [FIFO_DEPTH];

  logic [CW-1:0] occ;
  logic          gnt, fifo_empty, s1_rsp_valid, r_valid, push, pop;
  logic [DW-1:0] s1_rdata;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant only depends on stored + in-flight occupancy, never on lrdy.
  always_comb begin
    occ          = cnt_q + CW'(s1_valid_q);
    gnt          = tcdm_slave.req & ~clear_i & (occ < CW'(FIFO_DEPTH));
    fifo_empty   = (cnt_q == '0);
    s1_rsp_valid = s1_valid_q & s1_resp_q;
    s1_rdata     = s1_wen_q ? mem_data_i : '0;
    r_valid      = ~fifo_empty | s1_rsp_valid;
    pop          = ~fifo_empty & tcdm_slave.lrdy;
    push         = s1_rsp_valid & (~fifo_empty | ~tcdm_slave.lrdy);
  end

  assign tcdm_slave.gnt     = gnt;
  assign tcdm_slave.r_valid = r_valid;
  assign tcdm_slave.r_opc   = 1'b0;
  assign tcdm_slave.r_data  = ~r_valid  ? '0 :
                              fifo_empty ? s1_rdata : fifo_data_q[rptr_q];
  assign tcdm_slave.r_user  = ~r_valid  ? '0 :
                              fifo_empty ? s1_user_q : fifo_user_q[rptr_q];

  assign mem_req_o  = tcdm_slave.req & gnt;
  assign mem_add_o  = tcdm_slave.add;
  assign mem_wen_o  = tcdm_slave.wen;
  assign mem_be_o   = tcdm_slave.be;
  assign mem_data_o = tcdm_slave.data;

  always_comb begin
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fifo_data_d = fifo_data_q;
    fifo_user_d = fifo_user_q;
    s1_valid_d  = gnt;
    s1_wen_d    = s1_wen_q;
    s1_user_d   = s1_user_q;
    s1_resp_d   = s1_resp_q;
    if (gnt) begin
      s1_wen_d  = tcdm_slave.wen;
      s1_user_d = tcdm_slave.user;
      s1_resp_d = tcdm_slave.wen | R_VALID_ON_WRITE;
    end
    if (push) begin
      fifo_data_d[wptr_q] = s1_rdata;
      fifo_user_d[wptr_q] = s1_user_q;
      wptr_d              = wrap_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = wrap_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Flush drops both stored responses and the access still in flight.
    if (clear_i) begin
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_wen_q    <= 1'b0;
      s1_resp_q   <= 1'b0;
      s1_user_q   <= '0;
      fifo_data_q <= '{default: '0};
      fifo_user_q <= '{default: '0};
    end else begin
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_wen_q    <= s1_wen_d;
      s1_resp_q   <= s1_resp_d;
      s1_user_q   <= s1_user_d;
      fifo_data_q <= fifo_data_d;
      fifo_user_q <= fifo_user_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hci_core_r_responder.sv
// +--------------------------------------------------------------+
// | tb_hci_core_r_responder : two configurations against a       |
// | queue-based response model.  Rev 1.0                         |
// +--------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hci_core_r_responder;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int UW      = 1;
  localparam int BW      = DW / 8;
  localparam int DEPTH_A = 2;
  localparam int DEPTH_B = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;
  logic [DW-1:0] mem_data_i;
  always #5 clk_i = ~clk_i;

  logic          req, wen, lrdy;
  logic [AW-1:0] add;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic [UW-1:0] user;

  hci_core_intf #(.DW(DW), .AW(AW), .UW(UW)) if_a ();
  hci_core_intf #(.DW(DW), .AW(AW), .UW(UW)) if_b ();

  assign if_a.req = req;  assign if_a.wen = wen;  assign if_a.add = add;
  assign if_a.data = wdata; assign if_a.be = be; assign if_a.user = user;
  assign if_a.lrdy = lrdy;
  assign if_b.req = req;  assign if_b.wen = wen;  assign if_b.add = add;
  assign if_b.data = wdata; assign if_b.be = be; assign if_b.user = user;
  assign if_b.lrdy = lrdy;

  logic          mreq_a, mreq_b, mwen_a, mwen_b;
  logic [AW-1:0] madd_a, madd_b;
  logic [BW-1:0] mbe_a, mbe_b;
  logic [DW-1:0] mdat_a, mdat_b;

  hci_core_r_responder #(.DW(DW), .AW(AW), .UW(UW), .FIFO_DEPTH(DEPTH_A), .R_VALID_ON_WRITE(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .tcdm_slave(if_a),
    .mem_req_o(mreq_a), .mem_add_o(madd_a), .mem_wen_o(mwen_a), .mem_be_o(mbe_a),
    .mem_data_o(mdat_a), .mem_data_i(mem_data_i)
  );
  hci_core_r_responder #(.DW(DW), .AW(AW), .UW(UW), .FIFO_DEPTH(DEPTH_B), .R_VALID_ON_WRITE(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .tcdm_slave(if_b),
    .mem_req_o(mreq_b), .mem_add_o(madd_b), .mem_wen_o(mwen_b), .mem_be_o(mbe_b),
    .mem_data_o(mdat_b), .mem_data_i(mem_data_i)
  );

  logic [1:0]    o_gnt, o_rv, o_mreq, o_mwen, o_ropc;
  logic [DW-1:0] o_rdata [2];
  logic [UW-1:0] o_ruser [2];
  logic [AW-1:0] o_madd  [2];
  logic [BW-1:0] o_mbe   [2];
  logic [DW-1:0] o_mdat  [2];
  assign o_gnt  = {if_b.gnt, if_a.gnt};
  assign o_rv   = {if_b.r_valid, if_a.r_valid};
  assign o_ropc = {if_b.r_opc, if_a.r_opc};
  assign o_mreq = {mreq_b, mreq_a};
  assign o_mwen = {mwen_b, mwen_a};
  assign o_rdata[0] = if_a.r_data;  assign o_rdata[1] = if_b.r_data;
  assign o_ruser[0] = if_a.r_user;  assign o_ruser[1] = if_b.r_user;
  assign o_madd[0]  = madd_a;       assign o_madd[1]  = madd_b;
  assign o_mbe[0]   = mbe_a;        assign o_mbe[1]   = mbe_b;
  assign o_mdat[0]  = mdat_a;       assign o_mdat[1]  = mdat_b;

  // Reference model: responses waiting for delivery, plus the access granted last cycle.
  typedef struct packed { logic [DW-1:0] data; logic [UW-1:0] user; } rsp_t;
  rsp_t          mq [2][$];
  bit            s_v [2], s_wen [2], s_resp [2];
  logic [UW-1:0] s_user [2];
  rsp_t          s_rsp [2], e_head [2];
  bit            e_rv [2], e_gnt [2];
  int            depth [2] = '{DEPTH_A, DEPTH_B};
  bit            rvow  [2] = '{1'b1, 1'b0};
  int            n_cmp = 0, n_err = 0;
  int            rv_seen [2] = '{0, 0};
  int            gnt_seen [2] = '{0, 0};
  int            base;

  task automatic chk(input string tag, input int d,
                     input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      s_v[d] = 1'b0; s_wen[d] = 1'b0; s_resp[d] = 1'b0; s_user[d] = '0;
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [AW-1:0] a,
                       input bit l, input bit c, input logic [DW-1:0] md);
    req = r; wen = w; add = a; lrdy = l; clear_i = c; mem_data_i = md;
    wdata = $urandom; be = BW'($urandom); user = UW'($urandom);
  endtask

  task automatic check_now();
    #3;
    for (int d = 0; d < 2; d++) begin
      s_rsp[d].data = s_wen[d] ? mem_data_i : '0;
      s_rsp[d].user = s_user[d];
      e_rv[d]   = (mq[d].size() > 0) || (s_v[d] && s_resp[d]);
      e_head[d] = (mq[d].size() > 0) ? mq[d][0] : s_rsp[d];
      e_gnt[d]  = req && !clear_i && ((mq[d].size() + int'(s_v[d])) < depth[d]);
      chk("gnt", d, o_gnt[d], e_gnt[d]);
      chk("mem_req", d, o_mreq[d], e_gnt[d]);
      chk("r_valid", d, o_rv[d], e_rv[d]);
      chk("r_opc", d, o_ropc[d], 1'b0);
      chk("mem_add", d, o_madd[d], add);
      chk("mem_wen", d, o_mwen[d], wen);
      chk("mem_be", d, o_mbe[d], be);
      chk("mem_data", d, o_mdat[d], wdata);
      if (e_rv[d]) begin
        chk("r_data", d, o_rdata[d], e_head[d].data);
        chk("r_user", d, o_ruser[d], e_head[d].user);
      end
      if (o_rv[d]) rv_seen[d]++;
      if (o_gnt[d]) gnt_seen[d]++;
    end
  endtask

  task automatic advance();
    bit taken;
    @(posedge clk_i);
    for (int d = 0; d < 2; d++) begin
      if (clear_i) begin
        mq[d].delete();
        s_v[d] = 1'b0;
      end else begin
        taken = 1'b0;
        if (e_rv[d] && lrdy) begin
          if (mq[d].size() > 0) void'(mq[d].pop_front());
          else taken = 1'b1;
        end
        if (s_v[d] && s_resp[d] && !taken) mq[d].push_back(s_rsp[d]);
        s_v[d] = e_gnt[d];
        if (e_gnt[d]) begin
          s_wen[d]  = wen;
          s_user[d] = user;
          s_resp[d] = wen || rvow[d];
        end
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit w, input logic [AW-1:0] a,
                      input bit l, input bit c, input logic [DW-1:0] md);
    drive(r, w, a, l, c, md);
    check_now();
    advance();
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; mem_data_i = '0;
    req = 1'b0; wen = 1'b1; add = '0; wdata = '0; be = '0; user = '0; lrdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    req = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, o_gnt[d], 1'b1);
      chk("rst_mem_req", d, o_mreq[d], 1'b1);
      chk("rst_r_valid", d, o_rv[d], 1'b0);
      chk("rst_r_data", d, o_rdata[d], '0);
      chk("rst_r_user", d, o_ruser[d], '0);
      chk("rst_r_opc", d, o_ropc[d], 1'b0);
    end
    req = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single read, latency one.
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, $urandom);
    check_now();
    chk("rd_gnt_T", 0, o_gnt[0], 1'b1);
    advance();
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0, 32'hCAFE0001);
    check_now();
    chk("rd_valid_T1", 0, o_rv[0], 1'b1);
    chk("rd_data_T1", 0, o_rdata[0], 32'hCAFE0001);
    advance();
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);
    check_now();
    chk("rd_valid_T2", 0, o_rv[0], 1'b0);
    advance();

    // Write then read on the reads-only instance.
    base = rv_seen[1];
    step(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, $urandom);
    check_now();
    chk("wr_no_rsp", 1, o_rv[1], 1'b0);
    advance();
    drive(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);
    check_now();
    chk("rd_rsp", 1, o_rv[1], 1'b1);
    advance();
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);
    chk("one_rsp", 1, rv_seen[1] - base, 1);

    // Back-pressure fills the buffer, then drains in order.
    base = gnt_seen[0];
    repeat (4) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    chk("stall_grants", 0, gnt_seen[0] - base, 2);
    drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    check_now();
    chk("gnt_blocked", 0, o_gnt[0], 1'b0);
    advance();
    repeat (4) step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    check_now();
    chk("gnt_resume", 0, o_gnt[0], 1'b1);
    advance();

    // Toggling lrdy under continuous reads.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, $urandom, i[0], 1'b0, $urandom);
    repeat (4) step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);

    // Flush with one stored entry and one in flight.
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    drive(1'b1, 1'b1, $urandom, 1'b0, 1'b1, $urandom);
    check_now();
    chk("clr_gnt_low", 0, o_gnt[0], 1'b0);
    advance();
    drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    check_now();
    chk("clr_r_valid", 0, o_rv[0], 1'b0);
    chk("clr_gnt", 0, o_gnt[0], 1'b1);
    advance();
    repeat (4) step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom);
    repeat (4) step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);

    // Asynchronous reset with a full buffer.
    repeat (3) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, $urandom);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0, $urandom);
    check_now();
    chk("full_r_valid", 0, o_rv[0], 1'b1);
    rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_r_valid", d, o_rv[d], 1'b0);
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, $urandom);
    check_now();
    chk("post_rst_r_valid", 0, o_rv[0], 1'b0);
    chk("post_rst_gnt", 0, o_gnt[0], 1'b1);
    advance();
    repeat (3) step(1'b0, 1'b1, '0, 1'b1, 1'b0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
